// File: rtl/user_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : user_uart_tx
// Description : 8N1 UART transmitter with a small transmit FIFO. Bytes are
//               pushed with a valid/ready handshake and serialised LSB first
//               on a registered, idle-high line. Back-to-back frames are sent
//               with no idle gap while enable is high.
// Revision    : 1.0 - initial release
// ============================================================================
module user_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       enable,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_tx,
  output logic       uart_oeb,
  output logic       busy
);

  localparam int c_baud_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w  = c_ptr_w + 1;
  localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               r_state;
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic [c_baud_w-1:0]  r_baud;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift;
  logic                 r_tx_ready;
  logic                 r_uart_tx;
  logic                 r_uart_oeb;
  logic                 r_busy;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_bit_end;
  logic                 w_frame_done;
  logic                 w_active_next;
  logic [7:0]           w_head;
  logic [c_cnt_w-1:0]   w_count_next;

  // Handshake, bit timing and pop decisions shared by the FIFO and the FSM.
  // A pop happens from IDLE, or at the very end of STOP so frames chain
  // without an idle bit between them.
  assign w_push        = tx_valid && r_tx_ready;
  assign w_bit_end     = (r_baud == c_baud_last);
  assign w_frame_done  = (r_state == S_STOP) && w_bit_end;
  assign w_pop         = enable && (r_count != '0) &&
                         ((r_state == S_IDLE) || w_frame_done);
  assign w_head        = r_mem[r_rd_ptr];
  assign w_count_next  = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
  assign w_active_next = w_pop || ((r_state != S_IDLE) && !w_frame_done);

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  // FIFO pointers, occupancy and the registered status outputs. tx_ready and
  // busy are computed from next-cycle values so they track the state exactly.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tx_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_uart_oeb <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      r_count    <= w_count_next;
      r_tx_ready <= (w_count_next != c_depth);
      r_busy     <= w_active_next || (w_count_next != '0);
      r_uart_oeb <= 1'b0;
    end
  end

  // Frame sequencer: the baud counter restarts on every state entry and the
  // line level is registered alongside the state so it never glitches.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_uart_tx <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud    <= '0;
          r_uart_tx <= 1'b1;
          if (w_pop) begin
            r_shift   <= w_head;
            r_state   <= S_START;
            r_uart_tx <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_state   <= S_DATA;
            r_uart_tx <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
          end else begin
            r_baud <= r_baud + c_baud_w'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state   <= S_STOP;
              r_uart_tx <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_uart_tx <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baud <= r_baud + c_baud_w'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift   <= w_head;
              r_state   <= S_START;
              r_uart_tx <= 1'b0;
            end else begin
              r_state   <= S_IDLE;
              r_uart_tx <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + c_baud_w'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_uart_tx <= 1'b1;
        end
      endcase
    end
  end

  assign tx_ready = r_tx_ready;
  assign uart_tx  = r_uart_tx;
  assign uart_oeb = r_uart_oeb;
  assign busy     = r_busy;

endmodule
`default_nettype wire
